// File: rtl/seq_pkg.sv
// Shared types and constants for the decryption run controller.
package seq_pkg;

    // Run-controller phases; the encoding is only stored internally.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } seq_state_t;

    // Address whose non-zero processor write marks the job complete.
    localparam logic [7:0] DEFAULT_DONE_ADDR = 8'hFC;

endpackage : seq_pkg

// File: rtl/mem_port_mux.sv
// Combinational selector that hands the single data-memory port to the
// loader, the processor or the display reader depending on the phase.
module mem_port_mux
    import seq_pkg::*;
(
    input  seq_state_t  state_i,
    input  logic        ld_valid_i,
    input  logic [31:0] ld_data_i,
    input  logic [7:0]  lcnt_i,
    input  logic        cpu_we_i,
    input  logic [7:0]  cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    input  logic [7:0]  disp_addr_i,
    output logic        mem_we_o,
    output logic [7:0]  mem_addr_o,
    output logic [31:0] mem_wdata_o
);

    // Route the owning user onto the memory port; unowned phases keep it idle.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        mem_we_o    = 1'b0;
        mem_addr_o  = 8'h00;
        mem_wdata_o = 32'h0;
        case (state_i)
            ST_LOAD: begin
                mem_we_o    = ld_valid_i;
                mem_addr_o  = lcnt_i;
                mem_wdata_o = ld_data_i;
            end
            ST_RUN: begin
                mem_we_o    = cpu_we_i;
                mem_addr_o  = cpu_addr_i;
                mem_wdata_o = cpu_wdata_i;
            end
            ST_DONE: begin
                mem_addr_o  = disp_addr_i;
            end
            default: begin
                // IDLE and ERR: port parked at address 0, no writes.
            end
        endcase
    end

endmodule : mem_port_mux

// File: rtl/decrypt_sequencer.sv
// Run controller for the decryption core: sequences LOAD -> RUN -> DONE,
// holds the processor in reset outside RUN and times out a stuck run.
module decrypt_sequencer
    import seq_pkg::*;
#(
    parameter int         IMG_WORDS  = 64,
    parameter logic [7:0] DONE_ADDR  = DEFAULT_DONE_ADDR,
    parameter int         MAX_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_hold,
    input  logic [7:0]  disp_addr,
    output logic        disp_gnt,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int CW = $clog2(MAX_CYCLES + 1);

    localparam logic [7:0]    LAST_WORD = 8'(IMG_WORDS - 1);
    localparam logic [CW-1:0] LAST_CYC  = CW'(MAX_CYCLES - 1);

    seq_state_t    state_q, state_d;
    logic [7:0]    lcnt_q,  lcnt_d;
    logic [CW-1:0] ccnt_q,  ccnt_d;

    logic done_write;
    logic timeout;

    // A non-zero store to the completion address ends the run.
    assign done_write = cpu_we && (cpu_addr == DONE_ADDR) && (cpu_wdata != 32'h0);
    assign timeout    = (ccnt_q == LAST_CYC);

    // Next-state and counter update logic.
    always_comb begin
        state_d = state_q;
        lcnt_d  = lcnt_q;
        ccnt_d  = ccnt_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_LOAD;
                    lcnt_d  = 8'h00;
                    ccnt_d  = '0;
                end
            end
            ST_LOAD: begin
                // ld_ready is constantly high here, so ld_valid alone is the handshake.
                if (ld_valid) begin
                    lcnt_d = lcnt_q + 8'd1;
                    if (lcnt_q == LAST_WORD) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                ccnt_d = ccnt_q + CW'(1);
                // Completion takes priority over a coincident timeout.
                if (done_write) begin
                    state_d = ST_DONE;
                end else if (timeout) begin
                    state_d = ST_ERR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            lcnt_q  <= 8'h00;
            ccnt_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
            ccnt_q  <= ccnt_d;
        end
    end

    // Status and handshake outputs decode straight from the state register.
    assign ld_ready = (state_q == ST_LOAD);
    assign cpu_hold = (state_q != ST_RUN);
    assign disp_gnt = (state_q == ST_DONE);
    assign busy     = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign err      = (state_q == ST_ERR);

    mem_port_mux u_mem_port_mux (
        .state_i     (state_q),
        .ld_valid_i  (ld_valid),
        .ld_data_i   (ld_data),
        .lcnt_i      (lcnt_q),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .disp_addr_i (disp_addr),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata)
    );

endmodule : decrypt_sequencer

// File: tb/tb_decrypt_sequencer.sv
// Directed bench for decrypt_sequencer with a 4-word image and an 8-cycle run budget.
module tb_decrypt_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        cpu_we;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_hold;
    logic [7:0]  disp_addr;
    logic        disp_gnt;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Control vector layout: {cpu_hold, ld_ready, mem_we, disp_gnt, busy, done, err}
    localparam logic [6:0] C_IDLE   = 7'b1000000;
    localparam logic [6:0] C_LOADW  = 7'b1110100;
    localparam logic [6:0] C_STALL  = 7'b1100100;
    localparam logic [6:0] C_RUN    = 7'b0000100;
    localparam logic [6:0] C_RUNW   = 7'b0010100;
    localparam logic [6:0] C_DONE   = 7'b1001010;
    localparam logic [6:0] C_ERR    = 7'b1000001;

    decrypt_sequencer #(
        .IMG_WORDS  (4),
        .DONE_ADDR  (8'hFC),
        .MAX_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_hold  (cpu_hold),
        .disp_addr (disp_addr),
        .disp_gnt  (disp_gnt),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ctl();
        return {cpu_hold, ld_ready, mem_we, disp_gnt, busy, done, err};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One loader word accepted this cycle at the given address.
    task automatic load_word(input logic [7:0] addr, input logic [31:0] data);
        @(negedge clk);
        start    = 1'b0;
        ld_valid = 1'b1;
        ld_data  = data;
        #1;
        check("load_ctl",   32'(ctl()), 32'(C_LOADW));
        check("load_addr",  32'(mem_addr), 32'(addr));
        check("load_wdata", mem_wdata, data);
    endtask

    // Start pulse followed by a full 4-word load, ending on RUN cycle 1.
    task automatic start_and_load(input logic [31:0] base);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("start_to_ready", 32'(ld_ready), 32'd1);
        ld_valid = 1'b1;
        ld_data  = base;
        #1;
        check("load_addr0", 32'(mem_addr), 32'd0);
        for (int i = 1; i < 4; i++) begin
            load_word(8'(i), base + 32'(i));
        end
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        check("run_entry_ctl", 32'(ctl()), 32'(C_RUN));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        ld_valid  = 1'b0;
        ld_data   = 32'h0;
        cpu_we    = 1'b0;
        cpu_addr  = 8'h00;
        cpu_wdata = 32'h0;
        disp_addr = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Reset state held for 20 cycles with start low.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            check("reset_ctl",   32'(ctl()), 32'(C_IDLE));
            check("reset_addr",  32'(mem_addr), 32'h0);
            check("reset_wdata", mem_wdata, 32'h0);
        end

        // Start: ld_ready one cycle later, words A0..A3 to addresses 0..3, then RUN.
        @(negedge clk);
        start = 1'b1;
        #1;
        check("idle_on_start", 32'(ctl()), 32'(C_IDLE));
        for (int i = 0; i < 4; i++) begin
            load_word(8'(i), 32'hA0 + 32'(i));
        end
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        check("cpu_release", 32'(ctl()), 32'(C_RUN));

        // Zero write to the done address is an ordinary store.
        cpu_we    = 1'b1;
        cpu_addr  = 8'hFC;
        cpu_wdata = 32'h0;
        #1;
        check("zero_store_ctl",   32'(ctl()), 32'(C_RUNW));
        check("zero_store_addr",  32'(mem_addr), 32'hFC);
        check("zero_store_wdata", mem_wdata, 32'h0);

        // Non-zero write still reaches memory, then DONE on the next cycle.
        @(negedge clk);
        cpu_wdata = 32'h1;
        #1;
        check("done_write_ctl",   32'(ctl()), 32'(C_RUNW));
        check("done_write_wdata", mem_wdata, 32'h1);

        @(negedge clk);
        cpu_addr  = 8'h33;
        cpu_wdata = 32'h77;
        disp_addr = 8'h10;
        #1;
        check("done_ctl",   32'(ctl()), 32'(C_DONE));
        check("done_addr",  32'(mem_addr), 32'h10);
        check("done_wdata", mem_wdata, 32'h0);

        // Restart from DONE with a 3-cycle loader stall between words 1 and 2.
        @(negedge clk);
        cpu_we = 1'b0;
        start  = 1'b1;
        #1;
        check("done_on_start", 32'(ctl()), 32'(C_DONE));
        load_word(8'd0, 32'hB0);
        load_word(8'd1, 32'hB1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ld_valid = 1'b0;
            ld_data  = 32'hDEAD;
            #1;
            check("stall_ctl",  32'(ctl()), 32'(C_STALL));
            check("stall_addr", 32'(mem_addr), 32'd2);
        end
        load_word(8'd2, 32'hB2);
        load_word(8'd3, 32'hB3);
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        check("stall_run_entry", 32'(ctl()), 32'(C_RUN));

        // Timeout: RUN cycles 1..8 idle, ERR on the 9th.
        for (int c = 2; c <= 8; c++) begin
            @(negedge clk);
            #1;
            check("run_wait_ctl", 32'(ctl()), 32'(C_RUN));
        end
        @(negedge clk);
        cpu_we   = 1'b1;
        cpu_addr = 8'h55;
        #1;
        check("timeout_ctl",  32'(ctl()), 32'(C_ERR));
        check("timeout_addr", 32'(mem_addr), 32'h0);
        @(negedge clk);
        cpu_we = 1'b0;
        #1;
        check("err_sticky", 32'(ctl()), 32'(C_ERR));

        // Reload from ERR; start during RUN is ignored; done write on cycle 8 wins.
        start_and_load(32'hC0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("start_ignored_run", 32'(ctl()), 32'(C_RUN));
        for (int c = 4; c <= 7; c++) begin
            @(negedge clk);
            #1;
            check("run2_wait_ctl", 32'(ctl()), 32'(C_RUN));
        end
        @(negedge clk);
        cpu_we    = 1'b1;
        cpu_addr  = 8'hFC;
        cpu_wdata = 32'h5;
        #1;
        check("last_cycle_write", 32'(ctl()), 32'(C_RUNW));
        @(negedge clk);
        cpu_we = 1'b0;
        #1;
        check("done_beats_timeout", 32'(ctl()), 32'(C_DONE));

        // Reset mid-LOAD at lcnt = 2 drops the in-flight write.
        @(negedge clk);
        start = 1'b1;
        load_word(8'd0, 32'hD0);
        load_word(8'd1, 32'hD1);
        load_word(8'd2, 32'hD2);
        rst = 1'b0;
        #1;
        check("midload_reset_ctl",   32'(ctl()), 32'(C_IDLE));
        check("midload_reset_addr",  32'(mem_addr), 32'h0);
        check("midload_reset_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst      = 1'b1;
        ld_valid = 1'b0;
        #1;
        check("post_reset_idle", 32'(ctl()), 32'(C_IDLE));
        @(negedge clk);
        start = 1'b1;
        load_word(8'd0, 32'hE0);
        load_word(8'd1, 32'hE1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_decrypt_sequencer

// File: doc/decrypt_sequencer.md
# decrypt_sequencer

Top-level run controller for the decryption core. It owns the single data-memory port and gives it to one user per phase: image loader, processor, then display reader. Sequencing is LOAD → RUN → DONE. During LOAD and after completion the processor is held in reset. The block sits between the processor's memory outputs, the loader stream and the display read port on one side, and the data memory on the other.

## Interface
- `IMG_WORDS`, default 64: number of 32-bit words loaded at addresses 0..IMG_WORDS-1; range 1..255.
- `DONE_ADDR`, default 8'hFC: address whose non-zero write by the processor signals completion.
- `MAX_CYCLES`, default 100000: RUN-phase cycle budget before timeout.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins or restarts a job.
- `ld_valid`  in  1  loader word valid.
- `ld_data`  in  32  loader word.
- `ld_ready`  out  1  sequencer accepts the loader word.
- `cpu_we`  in  1  processor write enable (WR).
- `cpu_addr`  in  8  processor data address.
- `cpu_wdata`  in  32  processor write data.
- `cpu_hold`  out  1  high holds the processor in reset.
- `disp_addr`  in  8  display read address.
- `disp_gnt`  out  1  display owns memory; read data is valid.
- `mem_we`  out  1  data-memory write enable.
- `mem_addr`  out  8  data-memory address.
- `mem_wdata`  out  32  data-memory write data.
- `busy`  out  1  high in LOAD or RUN.
- `done`  out  1  high in DONE.
- `err`  out  1  high in ERR (timeout).

## Operation
- States: IDLE, LOAD, RUN, DONE, ERR. A load counter `lcnt` (8 bits) and a cycle counter `ccnt` (width `$clog2(MAX_CYCLES+1)`) are kept.
- Reset values: state IDLE, `lcnt` = 0, `ccnt` = 0. Outputs: `cpu_hold` = 1, `ld_ready` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `disp_gnt` = 0, `busy` = 0, `done` = 0, `err` = 0.
- IDLE, DONE or ERR, on `start`: go to LOAD and clear `lcnt` and `ccnt`. `start` in LOAD or RUN is ignored.
- LOAD:
  - `ld_ready` = 1; `mem_addr` = `lcnt`; `mem_wdata` = `ld_data`; `mem_we` = `ld_valid`.
  - On each handshake (`ld_valid` & `ld_ready`), `lcnt` increments.
  - The handshake at `lcnt` = IMG_WORDS-1 moves to RUN.
  - With `ld_valid` low the block waits indefinitely; there is no timeout in LOAD.
- RUN:
  - `cpu_hold` = 0; `mem_we`/`mem_addr`/`mem_wdata` pass `cpu_we`/`cpu_addr`/`cpu_wdata` through combinationally.
  - `ccnt` increments every cycle.
  - `cpu_we` & `cpu_addr` == DONE_ADDR & `cpu_wdata` != 0 moves to DONE. That write still reaches memory.
  - A write of zero to DONE_ADDR is an ordinary store.
  - When `ccnt` reaches MAX_CYCLES-1 without a done write, the next state is ERR.
  - If the done write and the timeout happen in the same cycle, DONE wins.
- DONE: `cpu_hold` = 1; `mem_we` = 0; `mem_addr` = `disp_addr`; `disp_gnt` = 1; `done` = 1.
- ERR: `cpu_hold` = 1; `mem_we` = 0; `mem_addr` = 0; `err` = 1. Only `start` or reset leaves ERR.
- IDLE: memory is idle (`mem_we` = 0, `mem_addr` = 0) and `cpu_hold` = 1.
- `busy` = (state == LOAD || state == RUN).

## Timing
- All state and counters are registered. `mem_*`, `ld_ready`, `disp_gnt` and the status outputs decode combinationally from the state register plus the listed pass-through inputs.
- State changes take effect on the clock edge after the triggering condition.
- `start` → `ld_ready` high: 1 cycle.
- Last load handshake → `cpu_hold` low: 1 cycle. The processor's first fetch is on the first RUN cycle.
- Done write → `cpu_hold` high and `disp_gnt` high: 1 cycle.
- A full load takes IMG_WORDS cycles with `ld_valid` held high.
- RUN lasts at most MAX_CYCLES cycles.
- Reset mid-operation:
  - Asynchronous return to IDLE; `cpu_hold` rises immediately.
  - Any in-flight memory write is dropped, because `mem_we` falls combinationally.
  - Memory contents are not cleared.
- `lcnt` cannot wrap, since IMG_WORDS ≤ 255 and LOAD exits first.

## Structure
- A shared package `seq_pkg` holds the `seq_state_t` enum (IDLE, LOAD, RUN, DONE, ERR) and the default DONE_ADDR constant.
- One sub-module, `mem_port_mux`: a combinational 3-way select of {loader, cpu, display} onto `mem_*`, driven by state.
- The FSM and counters live in `decrypt_sequencer`.

## Test plan
- Reset with `start` low: all outputs hold their reset values and `cpu_hold` = 1 for 20 cycles.
- IMG_WORDS = 4, `start`, `ld_valid` high with data 0xA0..0xA3 → writes to addresses 0..3 on consecutive cycles, then `cpu_hold` = 0 on the 5th cycle after `start`.
- Loader stalls: `ld_valid` low for 3 cycles between words 1 and 2 → no `mem_we` during the gap; addresses stay contiguous.
- In RUN, processor writes 0 then 0x1 to 0xFC → first write is an ordinary store; after the second, `done` = 1, `cpu_hold` = 1, `disp_gnt` = 1 next cycle, and `mem_addr` follows `disp_addr` = 0x10.
- MAX_CYCLES = 8 with no done write → `err` = 1 exactly 8 cycles after RUN entry. A done write on cycle 8 gives `done` instead. `start` from ERR reloads.
- Reset asserted mid-LOAD at `lcnt` = 2 → IDLE immediately with `mem_we` = 0. A subsequent `start` loads again from address 0.
